exe_branch_unit: RTL
====================

Name: exe_branch_unit

Overview:
- Execute-stage branch/jump resolution unit with prediction checking, a branch history table (BHT) and performance counters.
- Resolves B-type, JAL and JALR instructions and compares the actual outcome against the prediction carried down the pipe.
- Issues a registered redirect/flush on mispredict and trains a direct-mapped table of 2-bit saturating counters.
- The IF stage reads that table combinationally.

Parameters:
- DATA_WIDTH, 32, operand/instruction width
- ADDR_WIDTH, 32, PC width
- BHT_IDX_BITS, 6, log2 of BHT entries (64 entries)
- CNT_WIDTH, 32, performance counter width

Ports:
- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  asynchronous, active-low reset
- valid_i  in  1  EX-stage instruction valid
- inst_i  in  DATA_WIDTH  instruction word
- inst_addr_i  in  ADDR_WIDTH  PC of instruction
- op1_i  in  DATA_WIDTH  rs1 value
- op2_i  in  DATA_WIDTH  rs2 value
- pred_taken_i  in  1  IF-stage prediction carried with instruction
- pred_addr_i  in  ADDR_WIDTH  predicted next PC carried with instruction
- lookup_addr_i  in  ADDR_WIDTH  IF-stage PC for BHT lookup
- lookup_taken_o  out  1  BHT prediction (combinational)
- redirect_valid_o  out  1  registered flush/redirect strobe
- redirect_addr_o  out  ADDR_WIDTH  registered correct next PC
- branch_cnt_o  out  CNT_WIDTH  resolved branch/jump count
- mispredict_cnt_o  out  CNT_WIDTH  mispredict count

Behaviour:
- Reset (rst_i low, async): redirect_valid_o=0, redirect_addr_o=0, both counters=0, FSM=RUN, all BHT entries=2'b01 (weakly not-taken). Reset asserted mid-operation clears all of this immediately, including a pending redirect.
- Accepted instruction: valid_i=1 and FSM=RUN.
- Classification: opcode B-type with funct3 in {BEQ, BNE, BLT, BGE, BLTU, BGEU}, JAL, or JALR. Anything else, including B-type funct3 010/011, is a non-branch: no redirect, no BHT update, no count.
- Conditions: BLT/BGE use signed compare; BLTU/BGEU use unsigned compare.
- Targets:
  - B-type: inst_addr_i + sext(B-imm).
  - JAL: inst_addr_i + sext(J-imm); always taken.
  - JALR: (op1_i + sext(inst_i[31:20])) with bit0 forced to 0; always taken.
- Actual next PC = taken ? target : inst_addr_i + 4. All adds wrap modulo 2^ADDR_WIDTH.
- Mispredict = (taken != pred_taken_i) OR (taken AND target != pred_addr_i).
- Latency: on an accepted mispredict in cycle N:
  - redirect_valid_o=1 and redirect_addr_o=actual next PC during cycle N+1 only (single-cycle pulse).
  - redirect_addr_o holds its value afterwards.
- FSM:
  - RUN -> SHADOW on an accepted mispredict.
  - SHADOW -> RUN unconditionally after one cycle.
  - In SHADOW, valid_i is ignored (wrong-path instruction): no redirect, no BHT update, no count. Back-to-back redirects are therefore impossible.
- BHT:
  - Index = PC[BHT_IDX_BITS+1:2].
  - lookup_taken_o = entry[lookup index][1].
  - Update only for accepted conditional B-type: taken increments, not-taken decrements, saturating at 3 and 0.
  - JAL/JALR never update.
  - Write takes effect at the clock edge; a same-cycle lookup of the index being written returns the old value.
- Counters:
  - branch_cnt_o increments per accepted classified branch/jump.
  - mispredict_cnt_o increments per accepted mispredict.
  - Both saturate at all-ones (no wrap).

Test Plan:
- Reset, then read all 64 lookup indices -> lookup_taken_o=0 everywhere; counters=0; redirect_valid_o=0.
- BEQ at 0x100, op1=op2=5, imm=+16, pred_taken=0 -> cycle+1: redirect_valid_o=1, addr=0x110, mispredict_cnt=1. Next cycle's valid instruction is ignored (branch_cnt stays 1).
- BLT op1=0xFFFFFFFF, op2=1 -> taken. BLTU with same operands -> not taken. Both with correct prediction -> no redirect, branch_cnt=2.
- JALR op1=0x1001, imm=+2, pred_addr=0x1002, pred_taken=1 -> target 0x1002, no redirect. Same with pred_addr=0x1000 -> redirect to 0x1002.
- Four taken BNE at 0x200 with correct predictions -> entry 0 goes 01->10->11->11. Same-cycle lookup of 0x200 during the first update reads 0, next cycle reads 1. Invalid funct3 010 -> no BHT change.
- Force branch_cnt to all-ones via CNT_WIDTH=4 build and 17 branches -> holds at 15. Assert rst_i low while redirect pending -> redirect_valid_o drops immediately.

Source files
------------

// File: rtl/exe_branch_unit.sv
// Execute-stage branch/jump resolution unit.
//
// Resolves conditional branches, JAL and JALR, checks the outcome against the
// prediction carried down the pipe, and raises a one-cycle registered redirect
// when the two disagree. It also trains a direct-mapped table of 2-bit
// saturating counters that the fetch stage reads combinationally, and keeps
// saturating performance counters.
//
// Ports:
//   clk_i, rst_i                        clock; asynchronous active-low reset
//   valid_i, inst_i, inst_addr_i        EX-stage instruction and its PC
//   op1_i, op2_i                        rs1 / rs2 operand values
//   pred_taken_i, pred_addr_i           prediction made at fetch
//   lookup_addr_i, lookup_taken_o       fetch-stage BHT lookup
//   redirect_valid_o, redirect_addr_o   registered flush strobe and correct PC
//   branch_cnt_o, mispredict_cnt_o      performance counters
module exe_branch_unit #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned BHT_IDX_BITS = 6,
  parameter int unsigned CNT_WIDTH    = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  valid_i,
  input  logic [DATA_WIDTH-1:0] inst_i,
  input  logic [ADDR_WIDTH-1:0] inst_addr_i,
  input  logic [DATA_WIDTH-1:0] op1_i,
  input  logic [DATA_WIDTH-1:0] op2_i,
  input  logic                  pred_taken_i,
  input  logic [ADDR_WIDTH-1:0] pred_addr_i,
  input  logic [ADDR_WIDTH-1:0] lookup_addr_i,
  output logic                  lookup_taken_o,
  output logic                  redirect_valid_o,
  output logic [ADDR_WIDTH-1:0] redirect_addr_o,
  output logic [CNT_WIDTH-1:0]  branch_cnt_o,
  output logic [CNT_WIDTH-1:0]  mispredict_cnt_o
);

  localparam int unsigned BhtEntries = 1 << BHT_IDX_BITS;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;

  typedef enum logic [0:0] {StRun, StShadow} state_e;

  state_e                  state_q, state_d;
  logic                    redirect_valid_q, redirect_valid_d;
  logic [ADDR_WIDTH-1:0]   redirect_addr_q, redirect_addr_d;
  logic [CNT_WIDTH-1:0]    branch_cnt_q, branch_cnt_d;
  logic [CNT_WIDTH-1:0]    mispredict_cnt_q, mispredict_cnt_d;
  logic [1:0]              bht_q [BhtEntries];
  logic [1:0]              bht_d [BhtEntries];

  // Decode
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       is_cond, is_jal, is_jalr, is_branch, accepted;

  assign opcode    = inst_i[6:0];
  assign funct3    = inst_i[14:12];
  assign is_cond   = (opcode == OpBranch) && (funct3 != 3'b010) && (funct3 != 3'b011);
  assign is_jal    = (opcode == OpJal);
  assign is_jalr   = (opcode == OpJalr) && (funct3 == 3'b000);
  assign is_branch = is_cond || is_jal || is_jalr;
  // Instructions arriving in the shadow cycle are wrong-path and dropped.
  assign accepted  = valid_i && (state_q == StRun);

  // Immediates
  logic [12:0]           b_imm;
  logic [20:0]           j_imm;
  logic [ADDR_WIDTH-1:0] b_sext, j_sext, i_sext, jalr_sum;

  assign b_imm    = {inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
  assign j_imm    = {inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
  assign b_sext   = {{(ADDR_WIDTH-13){b_imm[12]}}, b_imm};
  assign j_sext   = {{(ADDR_WIDTH-21){j_imm[20]}}, j_imm};
  assign i_sext   = {{(ADDR_WIDTH-12){inst_i[31]}}, inst_i[31:20]};
  assign jalr_sum = op1_i[ADDR_WIDTH-1:0] + i_sext;

  // Resolution
  logic                  cond_true, taken, mispredict;
  logic [ADDR_WIDTH-1:0] target, seq_pc, next_pc;

  always_comb begin
    cond_true = 1'b0;
    case (funct3)
      3'b000:  cond_true = (op1_i == op2_i);
      3'b001:  cond_true = (op1_i != op2_i);
      3'b100:  cond_true = ($signed(op1_i) <  $signed(op2_i));
      3'b101:  cond_true = ($signed(op1_i) >= $signed(op2_i));
      3'b110:  cond_true = (op1_i <  op2_i);
      3'b111:  cond_true = (op1_i >= op2_i);
      default: cond_true = 1'b0;
    endcase
  end

  always_comb begin
    if (is_jalr) begin
      target = {jalr_sum[ADDR_WIDTH-1:1], 1'b0};
    end else if (is_jal) begin
      target = inst_addr_i + j_sext;
    end else begin
      target = inst_addr_i + b_sext;
    end
  end

  assign taken      = is_jal || is_jalr || (is_cond && cond_true);
  assign seq_pc     = inst_addr_i + ADDR_WIDTH'(4);
  assign next_pc    = taken ? target : seq_pc;
  // Target only matters when the branch is actually taken.
  assign mispredict = (taken != pred_taken_i) || (taken && (target != pred_addr_i));

  // BHT
  logic [BHT_IDX_BITS-1:0] upd_idx, lookup_idx;
  logic                    unused_lookup;

  assign upd_idx        = inst_addr_i[BHT_IDX_BITS+1:2];
  assign lookup_idx     = lookup_addr_i[BHT_IDX_BITS+1:2];
  assign lookup_taken_o = bht_q[lookup_idx][1];
  assign unused_lookup  = ^{lookup_addr_i[ADDR_WIDTH-1:BHT_IDX_BITS+2], lookup_addr_i[1:0]};

  always_comb begin
    bht_d = bht_q;
    if (accepted && is_cond) begin
      if (cond_true && (bht_q[upd_idx] != 2'b11)) begin
        bht_d[upd_idx] = bht_q[upd_idx] + 2'b01;
      end else if (!cond_true && (bht_q[upd_idx] != 2'b00)) begin
        bht_d[upd_idx] = bht_q[upd_idx] - 2'b01;
      end
    end
  end

  // Next state, redirect and counters
  always_comb begin
    state_d          = state_q;
    redirect_valid_d = 1'b0;
    redirect_addr_d  = redirect_addr_q;
    branch_cnt_d     = branch_cnt_q;
    mispredict_cnt_d = mispredict_cnt_q;
    unique case (state_q)
      StRun: begin
        if (accepted && is_branch) begin
          if (branch_cnt_q != '1) begin
            branch_cnt_d = branch_cnt_q + CNT_WIDTH'(1);
          end
          if (mispredict) begin
            state_d          = StShadow;
            redirect_valid_d = 1'b1;
            redirect_addr_d  = next_pc;
            if (mispredict_cnt_q != '1) begin
              mispredict_cnt_d = mispredict_cnt_q + CNT_WIDTH'(1);
            end
          end
        end
      end
      StShadow: state_d = StRun;
      default:  state_d = StRun;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q          <= StRun;
      redirect_valid_q <= 1'b0;
      redirect_addr_q  <= '0;
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
      for (int i = 0; i < BhtEntries; i++) begin
        bht_q[i] <= 2'b01;
      end
    end else begin
      state_q          <= state_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_addr_q  <= redirect_addr_d;
      branch_cnt_q     <= branch_cnt_d;
      mispredict_cnt_q <= mispredict_cnt_d;
      bht_q            <= bht_d;
    end
  end

  assign redirect_valid_o = redirect_valid_q;
  assign redirect_addr_o  = redirect_addr_q;
  assign branch_cnt_o     = branch_cnt_q;
  assign mispredict_cnt_o = mispredict_cnt_q;

endmodule
